// File: rtl/decoder_pkg.sv
// Shared types and per-opcode control constants for the pipelined instruction decoder.
package decoder_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_BNE  = 4'd3,
    OP_LW   = 4'd4,
    OP_LWW  = 4'd5,
    OP_LWG  = 4'd6,
    OP_MUL  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_JMP  = 4'd9,
    OP_HALT = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef struct packed {
    logic w;
    logic imm;
    logic w_in;
    logic g_in;
    logic bne;
    logic beq;
    logic jmp;
    logic mul;
    logic halt;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP     = '{default: 1'b0};
  localparam ctrl_t CTRL_ADD     = '{w: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_ADDI    = '{w: 1'b1, imm: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_BNE     = '{bne: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LW      = '{w: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LWW     = '{w: 1'b1, w_in: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LWG     = '{w: 1'b1, g_in: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_MUL     = '{w: 1'b1, mul: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_BEQ     = '{beq: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_JMP     = '{jmp: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_HALT    = '{halt: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_ILLEGAL = '{illegal: 1'b1, default: 1'b0};

endpackage

// File: rtl/decode_table.sv
// Combinational opcode-to-control lookup; ILLEGAL_TRAP_EN maps unknown opcodes to a trap, else to NOP.
module decode_table
  import decoder_pkg::*;
#(
  parameter int unsigned OPW  = 4,
  parameter int unsigned ALUW = 2
) (
  input  logic [OPW-1:0]  opcode,
  output ctrl_t           ctrl_c,
  output logic [ALUW-1:0] alufunc_c
);

`ifdef ILLEGAL_TRAP_EN
  localparam ctrl_t CTRL_BAD = CTRL_ILLEGAL;
`else
  localparam ctrl_t CTRL_BAD = CTRL_NOP;
`endif

  always_comb begin
    ctrl_c    = CTRL_BAD;
    alufunc_c = '0;
    if (opcode <= OPW'(OP_HALT)) begin
      case (opcode_e'(opcode[OPC_W-1:0]))
        OP_NOP:  ctrl_c = CTRL_NOP;
        OP_ADD:  ctrl_c = CTRL_ADD;
        OP_ADDI: ctrl_c = CTRL_ADDI;
        OP_BNE:  ctrl_c = CTRL_BNE;
        OP_LW:   ctrl_c = CTRL_LW;
        OP_LWW:  ctrl_c = CTRL_LWW;
        OP_LWG:  ctrl_c = CTRL_LWG;
        OP_MUL:  ctrl_c = CTRL_MUL;
        OP_BEQ:  ctrl_c = CTRL_BEQ;
        OP_JMP:  ctrl_c = CTRL_JMP;
        OP_HALT: ctrl_c = CTRL_HALT;
        default: ctrl_c = CTRL_BAD;
      endcase
    end
    // ALU function is the low opcode bits only for the arithmetic/memory group
    if (opcode <= OPW'(OP_MUL)) begin
      alufunc_c = opcode[ALUW-1:0];
    end
  end

endmodule

// File: rtl/pipe_decoder.sv
// Pipelined decoder: registered controls one cycle after accept, MUL stall, branch flush, halt.
// Optional feature macro: ILLEGAL_TRAP_EN (sticky trap and HALT on illegal opcodes).
module pipe_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALUW    = 2,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            instr_valid,
  input  logic [OPW-1:0]  opcode,
  input  logic            flag,
  output logic            instr_ready,
  output logic            PCincr,
  output logic            PCrelbranch,
  output logic [ALUW-1:0] ALUfunc,
  output logic            imm,
  output logic            w,
  output logic            w_in,
  output logic            g_in,
  output logic            busy,
  output logic            trap
);

  localparam int unsigned      CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  ctrl_t           ctrl_c;
  logic [ALUW-1:0] alufunc_c;

  decode_table #(
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_table (
    .opcode    (opcode),
    .ctrl_c    (ctrl_c),
    .alufunc_c (alufunc_c)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pcincr_d, pcrel_d, imm_d, w_d, w_in_d, g_in_d, ready_d, busy_d;
  logic [ALUW-1:0]  alufunc_d;
  logic             accept_c, branch_c, taken_c;

  assign accept_c = instr_valid & instr_ready;
  assign branch_c = ctrl_c.bne | ctrl_c.beq | ctrl_c.jmp;
  assign taken_c  = ctrl_c.jmp | (ctrl_c.bne & ~flag) | (ctrl_c.beq & flag);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcincr_d  = 1'b0;
    pcrel_d   = 1'b0;
    alufunc_d = '0;
    imm_d     = 1'b0;
    w_d       = 1'b0;
    w_in_d    = 1'b0;
    g_in_d    = 1'b0;
    case (state_q)
      RUN: begin
        // The cycle showing a taken branch is followed by the flush cycle
        if (PCrelbranch) begin
          state_d = FLUSH;
        end else if (accept_c) begin
          alufunc_d = alufunc_c;
          if (ctrl_c.illegal || ctrl_c.halt) begin
            state_d = HALT;
          end else if (branch_c) begin
            pcrel_d  = taken_c;
            pcincr_d = ~taken_c;
          end else if (ctrl_c.mul && (MUL_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = CNT_LOAD;
          end else begin
            pcincr_d = 1'b1;
            imm_d    = ctrl_c.imm;
            w_d      = ctrl_c.w;
            w_in_d   = ctrl_c.w_in;
            g_in_d   = ctrl_c.g_in;
          end
        end
      end
      STALL: begin
        alufunc_d = ALUfunc;
        if (cnt_q == CNT_ONE) begin
          state_d  = RUN;
          cnt_d    = '0;
          w_d      = 1'b1;
          pcincr_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH:   state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    ready_d = (state_d == RUN) && !pcrel_d;
    busy_d  = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      PCincr      <= 1'b0;
      PCrelbranch <= 1'b0;
      ALUfunc     <= '0;
      imm         <= 1'b0;
      w           <= 1'b0;
      w_in        <= 1'b0;
      g_in        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_ready <= ready_d;
      busy        <= busy_d;
      PCincr      <= pcincr_d;
      PCrelbranch <= pcrel_d;
      ALUfunc     <= alufunc_d;
      imm         <= imm_d;
      w           <= w_d;
      w_in        <= w_in_d;
      g_in        <= g_in_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky until reset
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      trap <= 1'b0;
    end else if (state_q == RUN && accept_c && ctrl_c.illegal) begin
      trap <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_decoder.sv
// Scoreboard bench for pipe_decoder: main instance at MUL_LAT=3, second at MUL_LAT=1.
module tb_pipe_decoder;

  logic       clk = 1'b0;
  logic       nReset;
  logic       valid0, flag0, valid1, flag1;
  logic [3:0] opcode0, opcode1;

  logic       rdy0, pci0, pcr0, imm0, w0, win0, gin0, busy0, trap0;
  logic [1:0] alu0;
  logic       rdy1, pci1, pcr1, imm1, w1, win1, gin1, busy1, trap1;
  logic [1:0] alu1;

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] exp0, exp1;
  logic [10:0] act0, act1;
  int          checks = 0;
  int          errors = 0;
  int          vec0 = 0;
  int          vec1 = 0;

  always #5 clk = ~clk;

  pipe_decoder #(.OPW(4), .ALUW(2), .MUL_LAT(3)) u_dut (
    .clk(clk), .nReset(nReset), .instr_valid(valid0), .opcode(opcode0), .flag(flag0),
    .instr_ready(rdy0), .PCincr(pci0), .PCrelbranch(pcr0), .ALUfunc(alu0),
    .imm(imm0), .w(w0), .w_in(win0), .g_in(gin0), .busy(busy0), .trap(trap0)
  );

  pipe_decoder #(.OPW(4), .ALUW(2), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .nReset(nReset), .instr_valid(valid1), .opcode(opcode1), .flag(flag1),
    .instr_ready(rdy1), .PCincr(pci1), .PCrelbranch(pcr1), .ALUfunc(alu1),
    .imm(imm1), .w(w1), .w_in(win1), .g_in(gin1), .busy(busy1), .trap(trap1)
  );

  assign act0 = {rdy0, busy0, trap0, pci0, pcr0, alu0, imm0, w0, win0, gin0};
  assign act1 = {rdy1, busy1, trap1, pci1, pcr1, alu1, imm1, w1, win1, gin1};

  function automatic logic [10:0] mk(input logic rdy, input logic bsy, input logic trp,
                                     input logic pci, input logic pcr, input logic [1:0] alu,
                                     input logic im, input logic wr, input logic wi, input logic gi);
    return {rdy, bsy, trp, pci, pcr, alu, im, wr, wi, gi};
  endfunction

  // One cycle of stimulus on the main instance; e is the output expected after the next edge
  task automatic cyc(input logic v, input logic [3:0] op, input logic f, input logic rst,
                     input logic [10:0] e);
    @(negedge clk);
    nReset  = rst;
    valid0  = v;
    opcode0 = op;
    flag0   = f;
    q0.push_back(e);
  endtask

  task automatic cyc1(input logic v, input logic [3:0] op, input logic f, input logic [10:0] e);
    @(negedge clk);
    valid1  = v;
    opcode1 = op;
    flag1   = f;
    q1.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      exp0 = q0.pop_front();
      vec0++;
      checks++;
      if (act0 !== exp0) begin
        errors++;
        $display("FAIL lat3 vec %0d got %b want %b (rdy bsy trp pci pcr alu imm w win gin)",
                 vec0, act0, exp0);
      end
    end
    if (q1.size() != 0) begin
      exp1 = q1.pop_front();
      vec1++;
      checks++;
      if (act1 !== exp1) begin
        errors++;
        $display("FAIL lat1 vec %0d got %b want %b (rdy bsy trp pci pcr alu imm w win gin)",
                 vec1, act1, exp1);
      end
    end
  end

  logic [10:0] idle_v, add_v, flush_v, halt_v, stall_v, muldone_v;

  initial begin
    idle_v    = mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    add_v     = mk(1, 0, 0, 1, 0, 2'd1, 0, 1, 0, 0);
    flush_v   = mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    halt_v    = mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    stall_v   = mk(0, 1, 0, 0, 0, 2'd3, 0, 0, 0, 0);
    muldone_v = mk(1, 0, 0, 1, 0, 2'd3, 0, 1, 0, 0);
    nReset = 1'b0;
    valid0 = 1'b0; opcode0 = 4'd0; flag0 = 1'b0;
    valid1 = 1'b0; opcode1 = 4'd0; flag1 = 1'b0;

    cyc(0, 4'd0, 0, 0, idle_v);
    cyc(1, 4'd1, 0, 0, idle_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    // ADDI then a bubble
    cyc(1, 4'd2, 0, 1, mk(1, 0, 0, 1, 0, 2'd2, 1, 1, 0, 0));
    cyc(0, 4'd0, 0, 1, idle_v);
    cyc(1, 4'd1, 0, 1, add_v);
    cyc(1, 4'd4, 0, 1, mk(1, 0, 0, 1, 0, 2'd0, 0, 1, 0, 0));
    cyc(1, 4'd5, 0, 1, mk(1, 0, 0, 1, 0, 2'd1, 0, 1, 1, 0));
    cyc(1, 4'd6, 0, 1, mk(1, 0, 0, 1, 0, 2'd2, 0, 1, 0, 1));
    cyc(1, 4'd0, 0, 1, mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
    // BNE taken: branch cycle, flush cycle, then ready again; ADDs offered meanwhile are ignored
    cyc(1, 4'd3, 0, 1, mk(0, 0, 0, 0, 1, 2'd3, 0, 0, 0, 0));
    cyc(1, 4'd1, 0, 1, flush_v);
    cyc(1, 4'd1, 0, 1, idle_v);
    cyc(1, 4'd1, 0, 1, add_v);
    // BNE not taken
    cyc(1, 4'd3, 1, 1, mk(1, 0, 0, 1, 0, 2'd3, 0, 0, 0, 0));
    cyc(1, 4'd1, 0, 1, add_v);
    // BEQ taken, BEQ not taken, JMP
    cyc(1, 4'd8, 1, 1, mk(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0));
    cyc(0, 4'd0, 0, 1, flush_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    cyc(1, 4'd8, 0, 1, mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
    cyc(1, 4'd9, 1, 1, mk(0, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0));
    cyc(0, 4'd0, 0, 1, flush_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    // MUL at latency 3
    cyc(1, 4'd7, 0, 1, stall_v);
    cyc(1, 4'd1, 0, 1, stall_v);
    cyc(1, 4'd1, 0, 1, muldone_v);
    cyc(1, 4'd1, 0, 1, add_v);
    // Reset in the middle of a MUL stall
    cyc(1, 4'd7, 0, 1, stall_v);
    cyc(0, 4'd0, 0, 0, idle_v);
    cyc(1, 4'd1, 0, 1, add_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    // HALT is terminal until reset
    cyc(1, 4'd10, 0, 1, halt_v);
    cyc(1, 4'd1, 0, 1, halt_v);
    cyc(1, 4'd1, 0, 1, halt_v);
    cyc(0, 4'd0, 0, 0, idle_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    // Illegal opcode 13
`ifdef ILLEGAL_TRAP_EN
    cyc(1, 4'd13, 0, 1, mk(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0));
    cyc(1, 4'd1, 0, 1, mk(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0));
    cyc(1, 4'd1, 0, 1, mk(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0));
`else
    cyc(1, 4'd13, 0, 1, mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
    cyc(1, 4'd11, 0, 1, mk(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0));
    cyc(1, 4'd1, 0, 1, add_v);
`endif
    cyc(0, 4'd0, 0, 0, idle_v);
    cyc(0, 4'd0, 0, 1, idle_v);
    // MUL_LAT=1 instance: MUL behaves like ADD
    cyc1(1, 4'd7, 0, muldone_v);
    cyc1(1, 4'd1, 0, add_v);
    cyc1(0, 4'd0, 0, idle_v);
    repeat (3) @(negedge clk);

    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q0.size() + q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
